win_scanner: RTL and testbench
==============================

WIN_SCANNER -- requirements
Module: win_scanner

Interface
REQ-001 Parameter STOP_ON_WIN, default 1: 1 = end scan at first winning line; 0 = always scan all 8 lines.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 pos1..pos9  input  2 each  board cells; 00 empty, 01 X, 10 O, 11 invalid.
REQ-006 busy  output  1  high in SNAP and SCAN states.
REQ-007 done  output  1  one-cycle pulse; results are valid in this cycle.
REQ-008 winner  output  2  00 none, 01 X, 10 O.
REQ-009 win_line  output  3  index of the reported winning line; 0 when winner=00.
REQ-010 draw  output  1  board full with no winner.
REQ-011 err  output  1  invalid board detected.

Function
REQ-012 The FSM SHALL have the states IDLE, SNAP, SCAN and DONE, and all outputs SHALL be registered.
REQ-013 IDLE: start=1 at an edge SHALL move the FSM to SNAP and clear winner, win_line, draw and err.
REQ-014 SNAP: the block SHALL copy pos1..pos9 into an internal snapshot, set line_idx=0, go to SCAN, and ignore all later pos changes for the rest of the scan.
REQ-015 SNAP: if any snapshot cell equals 11, err SHALL be set to 1 and the next state SHALL be DONE, skipping SCAN.
REQ-016 SCAN SHALL evaluate one line per cycle in this order: 0={1,2,3}, 1={4,5,6}, 2={7,8,9}, 3={1,4,7}, 4={2,5,8}, 5={3,6,9}, 6={1,5,9}, 7={3,5,7}.
REQ-017 A line SHALL win when its three cells are equal and non-zero.
REQ-018 The first winning line found SHALL set winner to its cell value and win_line to line_idx; later wins by the same player SHALL NOT change win_line.
REQ-019 If a later line is a win for the other player, the block SHALL set err=1 and clear winner to 00 and win_line to 0; this applies only when STOP_ON_WIN=0.
REQ-020 With STOP_ON_WIN=1, a win SHALL move the FSM to DONE on the next edge.
REQ-021 Otherwise line_idx SHALL increment each cycle, and the FSM SHALL go to DONE after line 7.
REQ-022 On entry to DONE, draw SHALL be set to 1 iff winner=00, err=0, and all nine snapshot cells are non-zero.
REQ-023 done=1 SHALL last exactly one cycle, in DONE, after which the FSM returns to IDLE.
REQ-024 winner, win_line, draw and err SHALL hold until the next accepted start or reset.
REQ-025 Latency, measured from the edge that samples start:
  - No early stop: done SHALL be high in cycle 10 (SNAP 1, SCAN 8, DONE 1).
  - Win on line k with STOP_ON_WIN=1: done SHALL be high in cycle k+3.
  - err at SNAP: done SHALL be high in cycle 2.
REQ-026 busy SHALL be 1 exactly in the SNAP and SCAN cycles; start while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 start held high continuously SHALL begin a new scan every time the FSM is in IDLE.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, line_idx=0, snapshot all zero, and busy, done, winner, win_line, draw, err all 0.
REQ-029 Reset asserted mid-scan SHALL abort with no done pulse; the first start after rst deasserts SHALL begin a fresh scan.

Verification
REQ-030 Empty board (all 00), start pulse -> done in cycle 10, winner=00, draw=0, err=0, busy high for 9 cycles.
REQ-031 X on cells 3,5,7 with STOP_ON_WIN=1 -> winner=01, win_line=7, done in cycle 10; same board with cells 1,2,3 also X -> win_line=0, done in cycle 3.
REQ-032 Full board X,O,X / X,O,O / O,X,X (pos1..pos9), start -> winner=00, draw=1, done in cycle 10.
REQ-033 pos5=11, start -> err=1, winner=00, done in cycle 2; with STOP_ON_WIN=0, rows 1 all X and row 2 all O -> err=1, winner=00.
REQ-034 Board changed to an O win on line 4 two cycles after start -> result reflects the snapshot only; a second start while busy -> no extra done pulse.
REQ-035 rst pulsed low during SCAN cycle 4 -> all outputs read 0 immediately and no done pulse; a new start then gives a correct result in cycle 10.

Source files
------------

// File: rtl/win_scanner_if.sv
// Board and result signals of the tic-tac-toe win scanner.
// The master drives the board and start; the slave reports the scan result.
interface win_scanner_if;
  logic       start;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [2:0] win_line;
  logic       draw;
  logic       err;

  modport master (
    output start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    input  busy, done, winner, win_line, draw, err
  );

  modport slave (
    input  start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    output busy, done, winner, win_line, draw, err
  );
endinterface

// File: rtl/win_scanner.sv
// Snapshots a 3x3 board on start, then checks one line per cycle for a win,
// reporting winner/line, draw or an invalid board with a one-cycle done pulse.
module win_scanner #(
  parameter bit STOP_ON_WIN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  win_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} state_t;

  state_t     state_reg;
  logic [1:0] snap_reg [9];
  logic [2:0] line_idx_reg;
  logic       busy_reg;
  logic       done_reg;
  logic [1:0] winner_reg;
  logic [2:0] win_line_reg;
  logic       draw_reg;
  logic       err_reg;

  logic [1:0] pos_in [9];
  logic [8:0] cell_bad;
  logic [8:0] cell_set;

  assign pos_in[0] = bus.pos1;
  assign pos_in[1] = bus.pos2;
  assign pos_in[2] = bus.pos3;
  assign pos_in[3] = bus.pos4;
  assign pos_in[4] = bus.pos5;
  assign pos_in[5] = bus.pos6;
  assign pos_in[6] = bus.pos7;
  assign pos_in[7] = bus.pos8;
  assign pos_in[8] = bus.pos9;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign cell_bad[gi] = (pos_in[gi] == 2'b11);
      assign cell_set[gi] = (snap_reg[gi] != 2'b00);
    end
  endgenerate

  logic [3:0] idx_a, idx_b, idx_c;
  logic [1:0] cell_a, cell_b, cell_c;
  logic       line_win;
  logic [1:0] winner_next;
  logic [2:0] win_line_next;
  logic       err_next;
  logic       scan_last;
  logic       draw_next;

  always_comb begin
    idx_a = 4'd0;
    idx_b = 4'd1;
    idx_c = 4'd2;
    case (line_idx_reg)
      3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
      3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
      3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
      3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
      3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
      3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
      3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
      default: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
    endcase

    cell_a   = snap_reg[idx_a];
    cell_b   = snap_reg[idx_b];
    cell_c   = snap_reg[idx_c];
    line_win = (cell_a != 2'b00) && (cell_a == cell_b) && (cell_b == cell_c);

    winner_next   = winner_reg;
    win_line_next = win_line_reg;
    err_next      = err_reg;
    // Once a conflict is flagged the result is frozen for the rest of the scan.
    if (line_win && !err_reg) begin
      if (winner_reg == 2'b00) begin
        winner_next   = cell_a;
        win_line_next = line_idx_reg;
      end else if (winner_reg != cell_a) begin
        err_next      = 1'b1;
        winner_next   = 2'b00;
        win_line_next = 3'd0;
      end
    end

    scan_last = (line_idx_reg == 3'd7) || (STOP_ON_WIN && line_win);
    draw_next = (&cell_set) && (winner_next == 2'b00) && !err_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      line_idx_reg <= 3'd0;
      for (int i = 0; i < 9; i++) snap_reg[i] <= 2'b00;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      winner_reg   <= 2'b00;
      win_line_reg <= 3'd0;
      draw_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg    <= SNAP;
            busy_reg     <= 1'b1;
            winner_reg   <= 2'b00;
            win_line_reg <= 3'd0;
            draw_reg     <= 1'b0;
            err_reg      <= 1'b0;
          end
        end
        SNAP: begin
          for (int i = 0; i < 9; i++) snap_reg[i] <= pos_in[i];
          line_idx_reg <= 3'd0;
          if (|cell_bad) begin
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          winner_reg   <= winner_next;
          win_line_reg <= win_line_next;
          err_reg      <= err_next;
          if (scan_last) begin
            draw_reg  <= draw_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            line_idx_reg <= line_idx_reg + 3'd1;
          end
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.winner   = winner_reg;
  assign bus.win_line = win_line_reg;
  assign bus.draw     = draw_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_win_scanner.sv
// Scoreboard bench for win_scanner: one instance stops on first win, the other
// scans all lines; both see the same boards and are checked on every done pulse.
module tb_win_scanner;

  typedef struct {
    logic [1:0] w;
    logic [2:0] l;
    logic       d;
    logic       e;
    int         lat;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] board [9];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int done1 = 0;
  int done0 = 0;
  int bc1 = 0;
  int bc0 = 0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t m1, m0;

  win_scanner_if if1();
  win_scanner_if if0();

  assign if1.start = start;
  assign if0.start = start;
  assign {if1.pos9, if1.pos8, if1.pos7, if1.pos6, if1.pos5, if1.pos4, if1.pos3, if1.pos2, if1.pos1} =
         {board[8], board[7], board[6], board[5], board[4], board[3], board[2], board[1], board[0]};
  assign {if0.pos9, if0.pos8, if0.pos7, if0.pos6, if0.pos5, if0.pos4, if0.pos3, if0.pos2, if0.pos1} =
         {board[8], board[7], board[6], board[5], board[4], board[3], board[2], board[1], board[0]};

  win_scanner #(.STOP_ON_WIN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  win_scanner #(.STOP_ON_WIN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse pops one expectation per instance.
  always @(negedge clk) begin
    if (!rst) begin
      bc1 = 0;
      bc0 = 0;
    end else begin
      if (if1.done) begin
        done1++;
        total++;
        $display("dut1 done cyc=%0d winner=%0d line=%0d draw=%0d err=%0d busy_cycles=%0d",
                 cyc, if1.winner, if1.win_line, if1.draw, if1.err, bc1);
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL dut1_unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          m1 = q1.pop_front();
          if ({if1.winner, if1.win_line, if1.draw, if1.err} !== {m1.w, m1.l, m1.d, m1.e}) begin
            bad++;
            $display("FAIL dut1_result: got w=%0d l=%0d d=%0d e=%0d, required w=%0d l=%0d d=%0d e=%0d",
                     if1.winner, if1.win_line, if1.draw, if1.err, m1.w, m1.l, m1.d, m1.e);
          end
          total++;
          if (cyc !== m1.cyc || bc1 !== m1.lat - 1 || if1.busy !== 1'b0) begin
            bad++;
            $display("FAIL dut1_timing: got cyc=%0d busy_cycles=%0d busy=%0d, required cyc=%0d busy_cycles=%0d busy=0",
                     cyc, bc1, if1.busy, m1.cyc, m1.lat - 1);
          end
        end
        bc1 = 0;
      end else if (if1.busy) begin
        bc1++;
      end

      if (if0.done) begin
        done0++;
        total++;
        $display("dut0 done cyc=%0d winner=%0d line=%0d draw=%0d err=%0d busy_cycles=%0d",
                 cyc, if0.winner, if0.win_line, if0.draw, if0.err, bc0);
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL dut0_unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          m0 = q0.pop_front();
          if ({if0.winner, if0.win_line, if0.draw, if0.err} !== {m0.w, m0.l, m0.d, m0.e}) begin
            bad++;
            $display("FAIL dut0_result: got w=%0d l=%0d d=%0d e=%0d, required w=%0d l=%0d d=%0d e=%0d",
                     if0.winner, if0.win_line, if0.draw, if0.err, m0.w, m0.l, m0.d, m0.e);
          end
          total++;
          if (cyc !== m0.cyc || bc0 !== m0.lat - 1 || if0.busy !== 1'b0) begin
            bad++;
            $display("FAIL dut0_timing: got cyc=%0d busy_cycles=%0d busy=%0d, required cyc=%0d busy_cycles=%0d busy=0",
                     cyc, bc0, if0.busy, m0.cyc, m0.lat - 1);
          end
        end
        bc0 = 0;
      end else if (if0.busy) begin
        bc0++;
      end
    end
  end

  function automatic logic [17:0] brd(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
    return {c9, c8, c7, c6, c5, c4, c3, c2, c1};
  endfunction

  function automatic exp_t mk(input logic [1:0] w, input logic [2:0] l, input logic d,
                              input logic e, input int lat);
    exp_t x;
    x.w = w; x.l = l; x.d = d; x.e = e; x.lat = lat; x.cyc = 0;
    return x;
  endfunction

  task automatic drive_board(input logic [17:0] b);
    for (int i = 0; i < 9; i++) board[i] = b[2*i +: 2];
  endtask

  // Cycle 1 is the cycle after the edge that samples start.
  task automatic launch(input logic [17:0] b, input exp_t e1, input exp_t e0, output int s);
    @(negedge clk);
    drive_board(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    e1.cyc = s + e1.lat - 1;
    e0.cyc = s + e0.lat - 1;
    q1.push_back(e1);
    q0.push_back(e0);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && q0.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (q1.size() != 0 || q0.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending results=%0d, required 0", nm, q1.size() + q0.size());
      q1.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_scan(input string nm, input logic [17:0] b, input exp_t e1, input exp_t e0);
    int s;
    launch(b, e1, e0, s);
    wait_drain(nm);
  endtask

  localparam logic [1:0] E = 2'b00, X = 2'b01, O = 2'b10, V = 2'b11;

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total += 2;
    if ({if1.busy, if1.done, if1.winner, if1.win_line, if1.draw, if1.err} !== 9'd0) begin
      bad++;
      $display("FAIL reset_dut1: got outputs %b, required 0", {if1.busy, if1.done, if1.winner, if1.win_line, if1.draw, if1.err});
    end
    if ({if0.busy, if0.done, if0.winner, if0.win_line, if0.draw, if0.err} !== 9'd0) begin
      bad++;
      $display("FAIL reset_dut0: got outputs %b, required 0", {if0.busy, if0.done, if0.winner, if0.win_line, if0.draw, if0.err});
    end
    rst = 1'b1;
  endtask

  task automatic test_wins();
    run_scan("empty", brd(E,E,E,E,E,E,E,E,E), mk(0,0,0,0,10), mk(0,0,0,0,10));
    run_scan("diag7", brd(E,E,X,E,X,E,X,E,E), mk(1,7,0,0,10), mk(1,7,0,0,10));
    run_scan("row0_and_diag7", brd(X,X,X,E,X,E,X,E,E), mk(1,0,0,0,3), mk(1,0,0,0,10));
    run_scan("o_col4", brd(E,O,E,E,O,E,E,O,E), mk(2,4,0,0,7), mk(2,4,0,0,10));
    run_scan("full_win7", brd(X,O,X,O,X,O,X,O,O), mk(1,7,0,0,10), mk(1,7,0,0,10));
  endtask

  task automatic test_draw();
    run_scan("draw", brd(X,O,X,X,O,O,O,X,X), mk(0,0,1,0,10), mk(0,0,1,0,10));
  endtask

  task automatic test_err();
    run_scan("invalid_cell", brd(E,E,E,E,V,E,E,E,E), mk(0,0,0,1,2), mk(0,0,0,1,2));
    run_scan("two_winners", brd(X,X,X,O,O,O,E,E,E), mk(1,0,0,0,3), mk(0,0,0,1,10));
  endtask

  task automatic test_snapshot();
    int s, d1, d0;
    d1 = done1;
    d0 = done0;
    launch(brd(E,E,E,E,E,E,E,E,E), mk(0,0,0,0,10), mk(0,0,0,0,10), s);
    @(negedge clk);
    drive_board(brd(E,O,E,E,O,E,E,O,E));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("snapshot");
    repeat (12) @(negedge clk);
    total++;
    if (done1 - d1 !== 1 || done0 - d0 !== 1) begin
      bad++;
      $display("FAIL snapshot_pulses: got %0d/%0d done pulses, required 1/1", done1 - d1, done0 - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d1, d0;
    d1 = done1;
    d0 = done0;
    @(negedge clk);
    drive_board(brd(E,E,E,E,E,E,E,E,E));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({if1.busy, if1.done, if1.winner, if1.win_line, if1.draw, if1.err,
         if0.busy, if0.done, if0.winner, if0.win_line, if0.draw, if0.err} !== 18'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy1=%0d busy0=%0d, required all outputs 0", if1.busy, if0.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (done1 !== d1 || done0 !== d0) begin
      bad++;
      $display("FAIL reset_mid_pulses: got %0d/%0d done pulses, required 0/0", done1 - d1, done0 - d0);
    end
    run_scan("after_reset", brd(E,E,X,E,X,E,X,E,E), mk(1,7,0,0,10), mk(1,7,0,0,10));
  endtask

  task automatic test_back_to_back();
    int s;
    exp_t e;
    @(negedge clk);
    drive_board(brd(E,E,E,E,E,E,E,E,E));
    start = 1'b1;
    @(negedge clk);
    s = cyc;
    e = mk(0,0,0,0,10);
    e.cyc = s + 9;
    q1.push_back(e);
    q0.push_back(e);
    repeat (11) @(negedge clk);
    start = 1'b0;
    e.cyc = s + 20;
    q1.push_back(e);
    q0.push_back(e);
    wait_drain("back_to_back");
  endtask

  initial begin
    for (int i = 0; i < 9; i++) board[i] = 2'b00;
    test_reset();
    test_wins();
    test_draw();
    test_err();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
